// File: rtl/fft_pingpong_buffer.sv
// Two-bank ping-pong store of N = 2^LOG2N complex samples; writes land on the sampling edge, reads are registered (1 cycle).
// Backpressure via bank ownership: wr_ready/rd_avail gate each side, illegal requests are dropped and flagged sticky.
module fft_pingpong_buffer #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [LOG2N-1:0]  wr_addr,
  input  logic              wr_bitrev,
  input  logic [DATA_W-1:0] wr_real,
  input  logic [DATA_W-1:0] wr_imag,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [LOG2N-1:0]  rd_addr,
  input  logic              rd_release,
  output logic              rd_avail,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_real,
  output logic [DATA_W-1:0] rd_imag,
  output logic              wr_sel_o,
  output logic              rd_sel_o,
  output logic              err_ovf,
  output logic              err_udf
);
  localparam int N = 1 << LOG2N;

  logic [2*DATA_W-1:0] mem [2*N];
  logic [1:0]          bank_full;
  logic [1:0]          bank_full_nxt;
  logic                wr_sel;
  logic                rd_sel;
  logic                wr_ok;
  logic                commit_ok;
  logic                rd_ok;
  logic                rel_ok;
  logic [LOG2N-1:0]    wr_phys;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign wr_ready  = !bank_full[wr_sel];
  assign rd_avail  = bank_full[rd_sel];
  assign wr_ok     = wr_en && wr_ready;
  assign commit_ok = wr_commit && wr_ready;
  assign rd_ok     = rd_en && rd_avail;
  assign rel_ok    = rd_release && rd_avail;
  assign wr_phys   = wr_bitrev ? bit_rev(wr_addr) : wr_addr;
  assign wr_sel_o  = wr_sel;
  assign rd_sel_o  = rd_sel;

  // Commit and release always target different banks when both are legal.
  always_comb begin
    bank_full_nxt = bank_full;
    if (commit_ok) bank_full_nxt[wr_sel] = 1'b1;
    if (rel_ok)    bank_full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_sel, wr_phys}] <= {wr_real, wr_imag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_real   <= '0;
      rd_imag   <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (commit_ok) wr_sel <= ~wr_sel;
      if (rel_ok)    rd_sel <= ~rd_sel;
      if ((wr_en || wr_commit) && !wr_ready) err_ovf <= 1'b1;
      if ((rd_en || rd_release) && !rd_avail) err_udf <= 1'b1;
      rd_valid <= rd_ok;
      // Read uses the pre-release bank even when rd_release fires in the same cycle.
      if (rd_ok) {rd_real, rd_imag} <= mem[{rd_sel, rd_addr}];
    end
  end
endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Scoreboard bench for fft_pingpong_buffer: directed stimulus pushes expected read data, a monitor pops on rd_valid.
module tb_fft_pingpong_buffer;
  localparam int DW = 32;
  localparam int LN = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [LN-1:0] wr_addr = '0;
  logic          wr_bitrev = 1'b0;
  logic [DW-1:0] wr_real = '0;
  logic [DW-1:0] wr_imag = '0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [LN-1:0] rd_addr = '0;
  logic          rd_release = 1'b0;
  logic          rd_avail;
  logic          rd_valid;
  logic [DW-1:0] rd_real;
  logic [DW-1:0] rd_imag;
  logic          wr_sel_o;
  logic          rd_sel_o;
  logic          err_ovf;
  logic          err_udf;

  fft_pingpong_buffer #(.DATA_W(DW), .LOG2N(LN)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bitrev(wr_bitrev),
    .wr_real(wr_real), .wr_imag(wr_imag), .wr_commit(wr_commit), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .rd_avail(rd_avail),
    .rd_valid(rd_valid), .rd_real(rd_real), .rd_imag(rd_imag),
    .wr_sel_o(wr_sel_o), .rd_sel_o(rd_sel_o), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: got %0h/%0h, expected no rd_valid", rd_real, rd_imag);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rd_real, rd_imag} !== mon_exp) begin
          miscompares++;
          $display("FAIL rd_data: got %0h/%0h, expected %0h/%0h",
                   rd_real, rd_imag, mon_exp[2*DW-1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input int re, input int im, input logic rev);
    wr_en = 1'b1; wr_addr = LN'(a); wr_real = DW'(re); wr_imag = DW'(im); wr_bitrev = rev;
    tick();
    wr_en = 1'b0; wr_bitrev = 1'b0;
  endtask

  task automatic do_read(input int a, input int er, input int ei);
    rd_en = 1'b1; rd_addr = LN'(a);
    exp_q.push_back({DW'(er), DW'(ei)});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic do_release();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_rd_avail", 64'(rd_avail), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_sels", 64'({wr_sel_o, rd_sel_o}), 64'd0);
    check("rst_errs", 64'({err_ovf, err_udf}), 64'd0);
    check("rst_rd_data", 64'({rd_real, rd_imag}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle_wr_ready", 64'(wr_ready), 64'd1);
    check("idle_rd_avail", 64'(rd_avail), 64'd0);

    // Natural-order frame into bank 0
    for (int k = 0; k < 8; k++) do_write(k, k, 100 + k, 1'b0);
    check("precommit_rd_avail", 64'(rd_avail), 64'd0);
    do_commit();
    check("commit_rd_avail", 64'(rd_avail), 64'd1);
    check("commit_wr_sel", 64'(wr_sel_o), 64'd1);
    check("commit_wr_ready", 64'(wr_ready), 64'd1);
    check("pre_read_valid", 64'(rd_valid), 64'd0);
    do_read(0, 0, 100);
    check("read_latency_valid", 64'(rd_valid), 64'd1);
    for (int k = 1; k < 8; k++) do_read(k, k, 100 + k);
    do_release();
    check("release_rd_sel", 64'(rd_sel_o), 64'd1);
    check("release_rd_avail", 64'(rd_avail), 64'd0);

    // Bit-reversed writes into bank 1
    for (int k = 0; k < 8; k++) do_write(k, k, 200 + k, 1'b1);
    do_commit();
    do_read(1, 4, 204);
    do_read(3, 6, 206);
    do_read(7, 7, 207);
    do_read(0, 0, 200);
    do_read(6, 3, 203);
    do_release();
    check("bitrev_sels", 64'({wr_sel_o, rd_sel_o}), 64'd0);

    // Ping-pong: frame A in bank 0, frame B written while A is read
    for (int k = 0; k < 8; k++) do_write(k, 10 + k, 20 + k, 1'b0);
    do_commit();
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_addr = LN'(k); wr_real = DW'(50 + k); wr_imag = DW'(60 + k);
      rd_en = 1'b1; rd_addr = LN'(k);
      exp_q.push_back({DW'(10 + k), DW'(20 + k)});
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
    end
    do_commit();
    check("both_full_wr_ready", 64'(wr_ready), 64'd0);
    check("both_full_wr_sel", 64'(wr_sel_o), 64'd0);
    check("both_full_err_ovf_pre", 64'(err_ovf), 64'd0);
    do_write(0, 32'hDEAD, 32'hDEAD, 1'b0);
    check("ovf_set", 64'(err_ovf), 64'd1);
    check("ovf_no_udf", 64'(err_udf), 64'd0);
    tick();
    check("ovf_sticky", 64'(err_ovf), 64'd1);
    // Release A while reading its addr 0: the dropped 0xDEAD write must not show
    rd_en = 1'b1; rd_addr = '0; rd_release = 1'b1;
    exp_q.push_back({DW'(10), DW'(20)});
    tick();
    rd_en = 1'b0; rd_release = 1'b0;
    check("pp_wr_ready", 64'(wr_ready), 64'd1);
    check("pp_wr_sel", 64'(wr_sel_o), 64'd0);
    check("pp_rd_sel", 64'(rd_sel_o), 64'd1);
    check("pp_rd_avail", 64'(rd_avail), 64'd1);
    for (int k = 0; k < 8; k++) do_read(k, 50 + k, 60 + k);

    // Commit and release in the same cycle
    do_write(5, 77, 88, 1'b0);
    wr_commit = 1'b1; rd_release = 1'b1;
    tick();
    wr_commit = 1'b0; rd_release = 1'b0;
    check("cr_sels", 64'({wr_sel_o, rd_sel_o}), 64'b10);
    check("cr_flags", 64'({wr_ready, rd_avail}), 64'b11);
    do_read(5, 77, 88);
    do_release();
    check("cr_empty_rd_avail", 64'(rd_avail), 64'd0);

    // Underflow and mid-frame reset
    rd_en = 1'b1; rd_addr = 3'd2;
    tick();
    rd_en = 1'b0;
    check("udf_rd_valid", 64'(rd_valid), 64'd0);
    check("udf_set", 64'(err_udf), 64'd1);
    check("udf_data_hold", 64'(rd_real), 64'd77);
    for (int k = 0; k < 3; k++) do_write(k, 300 + k, 400 + k, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_wr_ready", 64'(wr_ready), 64'd1);
    check("mrst_rd_avail", 64'(rd_avail), 64'd0);
    check("mrst_sels", 64'({wr_sel_o, rd_sel_o}), 64'd0);
    check("mrst_errs", 64'({err_ovf, err_udf}), 64'd0);
    check("mrst_rd", 64'({rd_valid, rd_real, rd_imag}), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
